mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises requests, drives a req/ack memory handshake, returns read data to the winner and generates per-stage stall signals for the pipeline registers.
- Sits between the IF/MEM stages and the memory model. Replaces their private memories.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, maximum cycles in a busy state without mem_ack before the access is aborted; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request, held until if_valid.
- if_addr  in  ADDR_W  fetch address (PC).
- if_valid  out  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_valid  out  1  one-cycle pulse: data access done.
- d_rdata  out  DATA_W  load data.
- stall_if  out  1  = if_req & ~if_valid (combinational).
- stall_d  out  1  = d_req & ~d_valid (combinational).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: state IDLE; mem_req/mem_we/if_valid/d_valid/err = 0; mem_addr/mem_wdata/if_rdata/d_rdata = 0; timer = 0; rr pointer = IF.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Eligible requester: its req is high and its valid is not high this cycle. This masks the requester just served, which still holds req for one cycle.
  - Both eligible: D wins (older instruction first).
  - Winner's addr/we/wdata are latched. For IF, mem_we = 0.
  - mem_req = 1 from the next cycle. Go to BUSY_I or BUSY_D.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Timer increments each cycle.
  - On mem_ack: mem_req = 0 next cycle; matching valid = 1 for exactly one cycle; rdata = mem_rdata (also for stores, value don't-care); timer = 0; go to IDLE.
- Minimum latency: req seen in cycle N → mem_req in N+1 → ack earliest in N+1 → valid in N+2. Back-to-back grant to the other requester is possible in the valid cycle.
- Timeout: if timer reaches TIMEOUT-1 with no ack, the access is aborted:
  - mem_req drops;
  - the requester's valid pulses with rdata = 0;
  - err = 1 (sticky until rst);
  - state goes to IDLE.
- mem_ack in IDLE (stray or late) is ignored.
- Requester inputs changing while in BUSY are ignored; latched copies are used.
- rst mid-access: everything returns to reset values the next cycle. The in-flight access is dropped with no valid pulse. A later ack is ignored.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on contention. A 1-bit last-served pointer is updated at every valid pulse; when both are eligible in IDLE, the requester not served last wins.
- Undefined: fixed priority, D over IF. The pointer logic is absent.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D); requester-id encoding (REQ_IF = 0, REQ_D = 1).
- Sub-module mem_arb_timer: counter with clear/enable/expire, width $clog2(TIMEOUT).
- Arbitration and FSM stay in the top module.

Test Plan:
- Lone fetch: if_req = 1, if_addr = 0x40; ack 2 cycles after mem_req with mem_rdata = 0x8C220004.
  - Expect mem_addr = 0x40, mem_we = 0.
  - Expect one if_valid with if_rdata = 0x8C220004.
  - Expect stall_if high until that cycle.
- Contention, fixed priority: if_req and d_req (load, 0x100) rise together.
  - Expect D served first, then IF issued in the d_valid cycle.
  - Expect no double grant to D.
- Store: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, immediate ack.
  - Expect mem_we = 1 and data stable until ack; d_valid 2 cycles after request.
- Timeout, TIMEOUT = 4: withhold mem_ack.
  - Expect mem_req to drop after 4 busy cycles, d_valid = 1 with d_rdata = 0, err = 1 held.
  - Expect a following fetch to still complete.
- Reset mid-access: assert rst during BUSY_I, then pulse mem_ack after reset.
  - Expect all outputs 0, no if_valid, and the ack ignored.
- MEM_ARB_RR_EN defined: both requesters held continuously for 4 accesses.
  - Expect grant order D, IF, D, IF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter for the arbiter; expire is high on the last allowed cycle
// of an access (count == TIMEOUT-1).
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM stages onto one single-port memory.
// Build option MEM_ARB_RR_EN: round-robin on contention instead of D-over-IF priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output arb_state_e        state_dbg
);

  // Handshake: a requester holds req (and its operands) until it sees its
  // one-cycle valid; mem_req/mem_we/mem_addr/mem_wdata stay stable until a
  // single-cycle mem_ack or the timeout, and mem_ack outside BUSY is ignored.

  arb_state_e state, state_next;
  logic elig_i, elig_d, grant_i, grant_d, done, abort;
  logic d_first, expire;

`ifdef MEM_ARB_RR_EN
  req_id_e last_served;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= REQ_IF;
    end else if (done) begin
      last_served <= (state == BUSY_D) ? REQ_D : REQ_IF;
    end
  end

  assign d_first = (last_served == REQ_IF);
`else
  assign d_first = 1'b1;
`endif

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    // The requester served last cycle still holds req during its valid cycle.
    elig_i     = if_req & ~if_valid;
    elig_d     = d_req & ~d_valid;
    case (state)
      IDLE: begin
        if (elig_d && (!elig_i || d_first)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (elig_i) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (expire) begin
          done       = 1'b1;
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      state    <= state_next;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (state == BUSY_I) begin
          if_valid <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end else begin
          d_valid <= 1'b1;
          d_rdata <= abort ? '0 : mem_rdata;
        end
        if (abort) begin
          err <= 1'b1;
        end
      end
    end
  end

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear ((state == IDLE) || done),
    .en    (state != IDLE),
    .expire(expire)
  );

  assign stall_if  = if_req & ~if_valid;
  assign stall_d   = d_req & ~d_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester agents, memory responder,
// transaction-level reference model with per-cycle compare, grant scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_valid, d_valid, stall_if, stall_d, mem_req, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  arb_state_e  state_dbg;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int ack_delay = 0;
  bit resp_en = 1'b1;
  int r_cnt = 0;
  bit r_done = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (!mem_req) begin
      r_cnt  = 0;
      r_done = 1'b0;
    end else if (resp_en && !r_done) begin
      if (r_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ 32'h8C22_0044;
        r_done    = 1'b1;
      end else begin
        r_cnt++;
      end
    end
  end

  // ---------------- requester agents ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } d_txn_t;

  logic [31:0] if_q[$];
  d_txn_t      d_q[$];
  d_txn_t      d_cur;
  bit          iv_s = 1'b0, dv_s = 1'b0;
  int unsigned if_start = 0, d_start = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (if_req && iv_s) if_req = 1'b0;
    if (!if_req && if_q.size() > 0) begin
      if_addr  = if_q.pop_front();
      if_req   = 1'b1;
      if_start = cyc;
    end
    if (d_req && dv_s) d_req = 1'b0;
    if (!d_req && d_q.size() > 0) begin
      d_cur   = d_q.pop_front();
      d_we    = d_cur.we;
      d_addr  = d_cur.addr;
      d_wdata = d_cur.wdata;
      d_req   = 1'b1;
      d_start = cyc;
    end
  end

  // ---------------- monitor + grant scoreboard ----------------
  logic [32:0] exp_q[$];
  int          if_cnt = 0, d_cnt = 0, req_hi = 0;
  int unsigned if_lat = 0, d_lat = 0;
  logic [31:0] if_rd = '0, d_rd = '0, grant_wdata = '0;
  logic        prev_req = 1'b0;

  initial forever begin
    @(negedge clk);
    iv_s = if_valid;
    dv_s = d_valid;
    if (if_valid === 1'b1) begin
      if_cnt++;
      if_lat = cyc - if_start;
      if_rd  = if_rdata;
    end
    if (d_valid === 1'b1) begin
      d_cnt++;
      d_lat = cyc - d_start;
      d_rd  = d_rdata;
    end
    if (mem_req === 1'b1) req_hi++;
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      grant_wdata = mem_wdata;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected: got we=%0b addr=0x%0h, want no grant", mem_we, mem_addr);
      end else begin
        check("grant_order", {mem_we, mem_addr}, exp_q.pop_front());
      end
    end
    prev_req = mem_req;
  end

  // ---------------- reference model ----------------
  // One outstanding access at a time; it ends on ack or after TO busy cycles.
  bit          m_busy = 0, m_who = 0, m_last = 0, m_ready = 0;
  int          m_age = 0;
  logic        e_req = 0, e_we = 0, e_iv = 0, e_dv = 0, e_err = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_ird = '0, e_drd = '0, m_r;
  bit          iv_now, dv_now, ei, ed, pick_d;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_who = 0; m_last = 0; m_age = 0;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0; e_err = 0;
      m_ready = 1;
    end else begin
      iv_now = e_iv;
      dv_now = e_dv;
      e_iv = 0;
      e_dv = 0;
      if (m_busy) begin
        if (mem_ack || m_age == TO - 1) begin
          m_r = mem_ack ? mem_rdata : 32'h0;
          if (!mem_ack) e_err = 1;
          if (m_who) begin e_dv = 1; e_drd = m_r; end
          else       begin e_iv = 1; e_ird = m_r; end
          m_last = m_who;
          m_busy = 0;
          m_age  = 0;
          e_req  = 0;
        end else begin
          m_age++;
        end
      end else begin
        ei = if_req && !iv_now;
        ed = d_req && !dv_now;
`ifdef MEM_ARB_RR_EN
        pick_d = ed && (!ei || m_last == 1'b0);
`else
        pick_d = ed;
`endif
        if (pick_d) begin
          m_busy = 1; m_who = 1; e_req = 1;
          e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        end else if (ei) begin
          m_busy = 1; m_who = 0; e_req = 1;
          e_we = 0; e_addr = if_addr;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      check("mem_req", mem_req, e_req);
      check("if_valid", if_valid, e_iv);
      check("d_valid", d_valid, e_dv);
      check("err", err, e_err);
      check("stall_if", stall_if, if_req && !e_iv);
      check("stall_d", stall_d, d_req && !e_dv);
      check("state", state_dbg, m_busy ? (m_who ? BUSY_D : BUSY_I) : IDLE);
      if (e_req) begin
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_iv) check("if_rdata", if_rdata, e_ird);
      if (e_dv) check("d_rdata", d_rdata, e_drd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name, input int max);
    int  n = 0;
    bit  idle = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
      idle = (if_req == 0 && d_req == 0 && if_q.size() == 0 && d_q.size() == 0 && mem_req == 0);
    end while (!idle && n < max);
    check(name, idle, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_if_valid"}, if_valid, 1'b0);
    check({tag, "_d_valid"}, d_valid, 1'b0);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rdata, 32'h0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  int if_c0, d_c0, exp_if_lat, exp_d_lat, n;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");

    // lone fetch, ack two cycles after mem_req
    @(posedge clk); #2;
    ack_delay = 2;
    if_c0 = if_cnt;
    exp_q.push_back({1'b0, 32'h40});
    if_q.push_back(32'h40);
    wait_idle("fetch_done", 40);
    check("fetch_latency", if_lat, 4);
    check("fetch_rdata", if_rd, 32'h8C22_0004);
    check("fetch_pulses", if_cnt - if_c0, 1);

    // contention: D wins, IF issued in the d_valid cycle
    ack_delay = 1;
    if_c0 = if_cnt; d_c0 = d_cnt;
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b0, 32'h44});
    d_q.push_back('{1'b0, 32'h100, 32'h0});
    if_q.push_back(32'h44);
    wait_idle("contend_done", 40);
    check("contend_d_latency", d_lat, 3);
    check("contend_if_latency", if_lat, 6);
    check("contend_d_rdata", d_rd, 32'h8C22_0144);
    check("contend_if_rdata", if_rd, 32'h8C22_0000);
    check("contend_d_pulses", d_cnt - d_c0, 1);
    check("contend_if_pulses", if_cnt - if_c0, 1);

    // store with immediate ack
    ack_delay = 0;
    exp_q.push_back({1'b1, 32'h200});
    d_q.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF});
    wait_idle("store_done", 40);
    check("store_latency", d_lat, 2);
    check("store_wdata", grant_wdata, 32'hDEAD_BEEF);

    // timeout on a load, then a fetch still completes
    resp_en = 1'b0;
    req_hi = 0;
    exp_q.push_back({1'b0, 32'h300});
    d_q.push_back('{1'b0, 32'h300, 32'h0});
    wait_idle("timeout_done", 40);
    check("timeout_req_cycles", req_hi, 4);
    check("timeout_latency", d_lat, 5);
    check("timeout_rdata", d_rd, 32'h0);
    check("timeout_err", err, 1'b1);
    resp_en = 1'b1;
    ack_delay = 1;
    exp_q.push_back({1'b0, 32'h48});
    if_q.push_back(32'h48);
    wait_idle("post_timeout_done", 40);
    check("post_timeout_latency", if_lat, 3);
    check("post_timeout_rdata", if_rd, 32'h8C22_000C);
    check("err_sticky", err, 1'b1);

    // both requesters held for four accesses
    if_c0 = if_cnt; d_c0 = d_cnt;
    d_q.push_back('{1'b0, 32'h400, 32'h0});
    d_q.push_back('{1'b0, 32'h408, 32'h0});
    if_q.push_back(32'h60);
    if_q.push_back(32'h64);
    exp_q.push_back({1'b0, 32'h400});
    exp_q.push_back({1'b0, 32'h60});
    exp_q.push_back({1'b0, 32'h408});
    exp_q.push_back({1'b0, 32'h64});
    wait_idle("stream_done", 80);
    check("stream_d_pulses", d_cnt - d_c0, 2);
    check("stream_if_pulses", if_cnt - if_c0, 2);
    check("stream_grants_left", exp_q.size(), 0);

    // contention right after a D access
    exp_q.push_back({1'b0, 32'h500});
    d_q.push_back('{1'b0, 32'h500, 32'h0});
    wait_idle("lone_load_done", 40);
    d_q.push_back('{1'b0, 32'h504, 32'h0});
    if_q.push_back(32'h4C);
`ifdef MEM_ARB_RR_EN
    exp_q.push_back({1'b0, 32'h4C});
    exp_q.push_back({1'b0, 32'h504});
    exp_if_lat = 3; exp_d_lat = 6;
`else
    exp_q.push_back({1'b0, 32'h504});
    exp_q.push_back({1'b0, 32'h4C});
    exp_if_lat = 6; exp_d_lat = 3;
`endif
    wait_idle("after_d_done", 40);
    check("after_d_if_latency", if_lat, exp_if_lat);
    check("after_d_d_latency", d_lat, exp_d_lat);

    // reset during BUSY_I, then a late ack
    resp_en = 1'b0;
    if_c0 = if_cnt;
    exp_q.push_back({1'b0, 32'h50});
    if_q.push_back(32'h50);
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (mem_req !== 1'b1 && n < 10);
    check("rst_test_busy", state_dbg, BUSY_I);
    @(posedge clk); #2;
    rst = 1'b1;
    if_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_zero_outputs("midrst");
    repeat (4) @(negedge clk);
    check("midrst_no_valid", if_cnt - if_c0, 0);
    check("midrst_req", mem_req, 1'b0);
    check("midrst_state", state_dbg, IDLE);
    resp_en = 1'b1;

    check("grants_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
